cordic_sched: RTL and testbench



---
 rtl/cordic_sched.sv | 190 +++++++++++++++++++
 tb/tb_cordic_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin front end sharing one free-running, fixed-latency CORDIC core.
// Define CORDIC_SCHED_STATS_EN to add the issue_cnt / stall_cnt statistics outputs.
module cordic_sched #(
    parameter int NREQ  = 4,
    parameter int LAT   = 15,
    parameter int DEPTH = 32,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [16*NREQ-1:0]   req_z,
    input  logic                 drain,
    output logic                 idle,
    output logic [15:0]          cx,
    output logic [15:0]          cy,
    output logic [15:0]          cz,
    input  logic [15:0]          rx,
    input  logic [15:0]          ry,
    input  logic [15:0]          rz,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [15:0]          res_x,
    output logic [15:0]          res_y,
    output logic [15:0]          res_z,
    output logic [IDW-1:0]       res_id,
    output logic [1:0]           state_dbg
`ifdef CORDIC_SCHED_STATS_EN
    ,
    output logic [31:0]          issue_cnt,
    output logic [31:0]          stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(LAT + 2);
    localparam int EW = IDW + 48;
    localparam logic [31:0] DEPTH_U = DEPTH;

    typedef enum logic [1:0] {S_RUN = 2'd0, S_HOLD = 2'd1, S_PAUSED = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            grant_en;
    logic [IDW-1:0]  ptr_q, ptr_d, gnt_idx, cand;
    logic            found, credit_ok, issue, push, pop;
    logic [15:0]     cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;
    logic [LAT:0]    tag_v_q, tag_v_d;
    logic [IDW-1:0]  tag_id_q [LAT+1];
    logic [IDW-1:0]  tag_id_d [LAT+1];
    logic [FW-1:0]   in_flight_q, in_flight_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   head;

    assign cx = cx_q;
    assign cy = cy_q;
    assign cz = cz_q;
    assign state_dbg = state_q;
    assign res_valid = (count_q != '0);
    assign head = mem_q[rd_ptr_q];
    assign {res_id, res_x, res_y, res_z} = res_valid ? head : '0;

    // Round-robin search starting at ptr_q; the first valid requester wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Handshake: req_ready is a one-hot grant; a request transfers on an edge where
    // req_valid[i] & req_ready[i]. Credits reserve a FIFO slot for every tag in flight.
    assign credit_ok = (32'(in_flight_q) + 32'(count_q)) < DEPTH_U;
    assign issue     = found && grant_en && credit_ok;
    assign push      = tag_v_q[LAT];
    assign pop       = res_valid && res_ready;

    always_comb begin
        req_ready = '0;
        cx_d      = cx_q;
        cy_d      = cy_q;
        cz_d      = cz_q;
        ptr_d     = ptr_q;
        if (issue) begin
            req_ready[gnt_idx] = 1'b1;
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_idx == IDW'(i)) begin
                    cx_d = req_x[16*i +: 16];
                    cy_d = req_y[16*i +: 16];
                    cz_d = req_z[16*i +: 16];
                end
            end
        end
        tag_v_d     = {tag_v_q[LAT-1:0], issue};
        tag_id_d[0] = gnt_idx;
        for (int i = 1; i <= LAT; i++) tag_id_d[i] = tag_id_q[i-1];
        in_flight_d = in_flight_q + FW'(issue) - FW'(push);
        count_d     = count_q + CW'(push) - CW'(pop);
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            cz_q        <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '{default: '0};
            in_flight_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            cz_q        <= cz_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {tag_id_q[LAT], rx, ry, rz};
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (drain) state_d = S_HOLD;
            S_HOLD: begin
                if (!drain)                                  state_d = S_RUN;
                else if (in_flight_q == '0 && count_q == '0) state_d = S_PAUSED;
            end
            S_PAUSED: if (!drain) state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    always_comb begin
        grant_en = (state_q == S_RUN);
        idle     = (state_q == S_PAUSED);
    end

`ifdef CORDIC_SCHED_STATS_EN
    logic [31:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (issue && issue_cnt_q != '1) issue_cnt_d = issue_cnt_q + 32'd1;
        if ((|req_valid) && !issue && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: a delay-line core model, an expected-result queue filled on
// acceptance and a negedge monitor that pops and compares every delivered result.
module tb_cordic_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 15;
    localparam int DEPTH = 32;
    localparam int IDW  = 2;
    localparam int EW   = IDW + 48;

    logic                clk, rst, drain, idle, res_valid, res_ready;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [16*NREQ-1:0]  req_x, req_y, req_z;
    logic [15:0]         cx, cy, cz, rx, ry, rz, res_x, res_y, res_z;
    logic [IDW-1:0]      res_id;
    logic [1:0]          state_dbg;
`ifdef CORDIC_SCHED_STATS_EN
    logic [31:0]         issue_cnt, stall_cnt;
`endif

    cordic_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .drain(drain), .idle(idle),
        .cx(cx), .cy(cy), .cz(cz), .rx(rx), .ry(ry), .rz(rz),
        .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
        .res_z(res_z), .res_id(res_id), .state_dbg(state_dbg)
`ifdef CORDIC_SCHED_STATS_EN
        , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- core model: LAT-edge delay line with a fixed transform ----------------
    logic [15:0] px [LAT];
    logic [15:0] py [LAT];
    logic [15:0] pz [LAT];
    always @(posedge clk) begin
        px[0] <= cx;
        py[0] <= cy;
        pz[0] <= cz;
        for (int i = 1; i < LAT; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
            pz[i] <= pz[i-1];
        end
    end
    assign rx = px[LAT-1] + 16'h0100;
    assign ry = py[LAT-1] ^ 16'h00FF;
    assign rz = pz[LAT-1] - 16'h0001;

    // ---------------- operand generation ----------------
    logic [15:0] xbase [NREQ];
    logic [15:0] ybase [NREQ];
    logic [15:0] zbase [NREQ];
    int          seq   [NREQ];
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_x[16*i +: 16] = xbase[i] + 16'(seq[i]);
            req_y[16*i +: 16] = ybase[i] + 16'(3 * seq[i]);
            req_z[16*i +: 16] = zbase[i] - 16'(seq[i]);
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int glog_id[$];
    int glog_cyc[$];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int n_pops = 0;
    int acc_issue = 0;
    int acc_stall = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            exp_q.delete();
            acc_issue = 0;
            acc_stall = 0;
            for (int i = 0; i < NREQ; i++) seq[i] <= 0;
        end else begin
            if ((|req_valid) && (req_ready == '0)) acc_stall++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({IDW'(i), req_x[16*i +: 16] + 16'h0100,
                                     req_y[16*i +: 16] ^ 16'h00FF, req_z[16*i +: 16] - 16'h0001});
                    glog_id.push_back(i);
                    glog_cyc.push_back(cyc);
                    acc_issue++;
                    seq[i] <= seq[i] + 1;
                end
            end
        end
    end

    // Monitor: grant sanity every cycle, result comparison on every pop.
    always @(negedge clk) begin
        if (!rst) begin
            check("grant_onehot_valid", {63'd0, ($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0)}, 64'd1);
            if (res_valid && res_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {res_id, res_x, res_y, res_z}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("result", {res_id, res_x, res_y, res_z}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || res_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_grants(input int target, input string name);
        int t = 0;
        while (glog_id.size() < target && t < 100) begin
            step();
            t++;
        end
        check(name, {63'd0, t < 100}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int g0, c0, p0, t;
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        drain = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            xbase[i] = 16'(16'h1000 * (i + 1));
            ybase[i] = 16'h0A00 + 16'(i);
            zbase[i] = 16'hF000 - 16'(i * 256);
        end
        repeat (3) step();
        rst = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", {res_id, res_x, res_y, res_z}, 0);
        check("rst_idle", idle, 0);
        check("rst_core_ops", {cx, cy, cz}, 0);
        check("rst_state", state_dbg, 0);

        // Single op from requester 2
        xbase[2] = 16'h4DBA;
        ybase[2] = 16'h0000;
        zbase[2] = 16'h1922;
        step();
        req_valid = 4'b0100;
        @(negedge clk);
        check("t1_ready", req_ready, 4'b0100);
        c0 = cyc;
        step();
        req_valid = '0;
        @(negedge clk);
        check("t1_ready_once", req_ready, 0);
        check("t1_cx", cx, 16'h4DBA);
        check("t1_cz", cz, 16'h1922);
        t = 0;
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t1_latency", cyc - c0, 17);
        check("t1_res_id", res_id, 2);
        check("t1_res_x", res_x, 16'h4EBA);
        check("t1_res_y", res_y, 16'h00FF);
        check("t1_res_z", res_z, 16'h1921);
        wait_drain("t1_drained");

        // Round robin at full throughput; pointer sits after requester 2
        g0 = glog_id.size();
        step();
        req_valid = 4'hF;
        repeat (40) step();
        req_valid = '0;
        check("t2_grant_count", glog_id.size() - g0, 40);
        for (int j = 0; j < 40; j++) begin
            check("t2_grant_order", glog_id[g0 + j], (3 + j) % 4);
            check("t2_no_gap", glog_cyc[g0 + j] - glog_cyc[g0], j);
        end
        wait_drain("t2_drained");

        // Reset with 8 ops in flight
        g0 = glog_id.size();
        step();
        req_valid = 4'hF;
        wait_grants(g0 + 8, "t5_wait_grants");
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int j = 0; j < LAT + 5; j++) begin
            @(negedge clk);
            check("t5_no_stale", res_valid, 0);
        end
        check("t5_state", state_dbg, 0);
        g0 = glog_id.size();
        step();
        req_valid = 4'hF;
        repeat (4) step();
        req_valid = '0;
        for (int j = 0; j < 4; j++) check("t5_ptr_order", glog_id[g0 + j], j);
        wait_drain("t5_drained");

        // Credit exhaustion with the consumer stalled
        res_ready = 1'b0;
        g0 = glog_id.size();
        p0 = n_pops;
        step();
        req_valid = 4'b0001;
        repeat (50) step();
        check("t3_credit_grants", glog_id.size() - g0, DEPTH);
        @(negedge clk);
        check("t3_ready_low", req_ready, 0);
        check("t3_res_valid", res_valid, 1);
        step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        repeat (10) step();
        check("t3_one_more_grant", glog_id.size() - g0, DEPTH + 1);
        @(negedge clk);
        check("t3_ready_low_again", req_ready, 0);
        step();
        req_valid = '0;
        res_ready = 1'b1;
        wait_drain("t3_drained");
        check("t3_pops", n_pops - p0, DEPTH + 1);

        // Drain with 10 ops in flight
        g0 = glog_id.size();
        p0 = n_pops;
        step();
        req_valid = 4'b0010;
        wait_grants(g0 + 9, "t4_wait_grants");
        drain = 1'b1;
        repeat (5) step();
        check("t4_grants_stop", glog_id.size() - g0, 10);
        t = 0;
        while (!idle && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t4_idle", idle, 1);
        check("t4_state_paused", state_dbg, 2);
        check("t4_grants_held", glog_id.size() - g0, 10);
        check("t4_results", n_pops - p0, 10);
        check("t4_queue_empty", exp_q.size(), 0);
        step();
        drain = 1'b0;
        @(negedge clk);
        check("t4_still_paused", {idle, req_ready}, {1'b1, 4'b0000});
        @(negedge clk);
        check("t4_resume", {idle, req_ready}, {1'b0, 4'b0010});
        step();
        req_valid = '0;
        wait_drain("t4_drained");
        check("t4_resume_grant", glog_id.size() - g0, 11);

`ifdef CORDIC_SCHED_STATS_EN
        @(negedge clk);
        check("stats_issue", issue_cnt, acc_issue);
        check("stats_stall", stall_cnt, acc_stall);
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
